// File: rtl/rr_write_arbiter.sv
// Round-robin arbiter: NUM_WRITERS busy/request writers share one FIFO write port.
// Optional macro ARB_STATS_EN adds per-writer 16-bit saturating write counters (o_write_count).
module rr_write_arbiter #(
    parameter int NUM_WRITERS = 4,
    parameter int DATA_WIDTH  = 8,
    localparam int ID_W       = $clog2(NUM_WRITERS)
) (
    input  logic                              i_clk,
    input  logic                              i_reset_n,
    input  logic [NUM_WRITERS*DATA_WIDTH-1:0] i_data,
    input  logic [NUM_WRITERS-1:0]            i_req,
    input  logic                              i_full,
    output logic [NUM_WRITERS-1:0]            o_busy,
    output logic [DATA_WIDTH-1:0]             o_data,
    output logic                              o_we,
`ifdef ARB_STATS_EN
    output logic [NUM_WRITERS*16-1:0]         o_write_count,
`endif
    output logic [ID_W-1:0]                   o_grant_id
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        WRITE = 2'd2
    } state_e;

    localparam logic [ID_W-1:0]        LAST_ID  = ID_W'(NUM_WRITERS - 1);
    localparam logic [NUM_WRITERS-1:0] ONE_HOT0 = NUM_WRITERS'(1);

    state_e                 state_q, state_d;
    logic [ID_W-1:0]        ptr_q, ptr_d;
    logic [ID_W-1:0]        grant_id_q, grant_id_d;
    logic [DATA_WIDTH-1:0]  data_q, data_d;
    logic [NUM_WRITERS-1:0] busy_q, busy_d;
    logic [NUM_WRITERS-1:0] elig_s;
    logic                   found_s;
    logic [ID_W-1:0]        pick_s;
    logic                   we_s;

    // Returns {found, index}: first eligible writer after ptr, wrapping at NUM_WRITERS.
    function automatic logic [ID_W:0] rr_pick(input logic [NUM_WRITERS-1:0] elig,
                                              input logic [ID_W-1:0]        ptr);
        logic            found;
        logic [ID_W-1:0] idx;
        logic [ID_W-1:0] cand;
        found = 1'b0;
        idx   = '0;
        cand  = ptr;
        for (int i = 0; i < NUM_WRITERS; i++) begin
            if (cand == LAST_ID) begin
                cand = '0;
            end else begin
                cand = cand + ID_W'(1);
            end
            if (!found && elig[cand]) begin
                found = 1'b1;
                idx   = cand;
            end else begin
                found = found;
            end
        end
        return {found, idx};
    endfunction

    // Eligible requests: the writer just served may still show a stale request while in WRITE.
    always_comb begin
        elig_s = i_req;
        if (state_q == WRITE) begin
            elig_s = i_req & ~(ONE_HOT0 << grant_id_q);
        end else begin
            elig_s = i_req;
        end
    end

    // Round-robin winner among eligible requests.
    always_comb begin
        {found_s, pick_s} = rr_pick(elig_s, ptr_q);
    end

    // Write strobe follows the registered state; FIFO full suppresses it in the same cycle.
    assign we_s = (state_q == WRITE) && !i_full;

    // Next-state and next-register logic for the IDLE/GRANT/WRITE controller.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_id_d = grant_id_q;
        data_d     = data_q;
        busy_d     = '1;
        case (state_q)
            IDLE: begin
                if (found_s && !i_full) begin
                    state_d    = GRANT;
                    ptr_d      = pick_s;
                    grant_id_d = pick_s;
                    busy_d     = ~(ONE_HOT0 << pick_s);
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                data_d  = i_data[grant_id_q*DATA_WIDTH +: DATA_WIDTH];
                state_d = WRITE;
            end
            WRITE: begin
                if (i_full) begin
                    state_d = WRITE;
                end else if (found_s) begin
                    state_d    = GRANT;
                    ptr_d      = pick_s;
                    grant_id_d = pick_s;
                    busy_d     = ~(ONE_HOT0 << pick_s);
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset discards any captured word.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= IDLE;
            ptr_q      <= LAST_ID;
            grant_id_q <= '0;
            data_q     <= '0;
            busy_q     <= '1;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_id_q <= grant_id_d;
            data_q     <= data_d;
            busy_q     <= busy_d;
        end
    end

    assign o_busy     = busy_q;
    assign o_data     = data_q;
    assign o_we       = we_s;
    assign o_grant_id = grant_id_q;

`ifdef ARB_STATS_EN
    for (genvar k = 0; k < NUM_WRITERS; k++) begin : g_cnt
        logic [15:0] cnt_q;

        // Saturating count of writes issued on behalf of writer k.
        always_ff @(posedge i_clk or negedge i_reset_n) begin
            if (!i_reset_n) begin
                cnt_q <= 16'h0000;
            end else if (we_s && (grant_id_q == ID_W'(k)) && (cnt_q != 16'hFFFF)) begin
                cnt_q <= cnt_q + 16'd1;
            end else begin
                cnt_q <= cnt_q;
            end
        end

        assign o_write_count[k*16 +: 16] = cnt_q;
    end
`endif

endmodule
